// File: rtl/pcs_tx_seq_ctrl.sv
// TX sequencer for the 25G PCS 192-bit datapath: alignment preamble, IDLE fill and payload arbitration.
// Outputs are combinational from state; align_done/underrun are registered one-cycle pulses.

`ifndef ESC_CHAR
`define ESC_CHAR 48'h1C1C_1C1C_1C1C
`endif
`ifndef IDLE_CHAR
`define IDLE_CHAR 48'h0707_0707_0707
`endif
`ifndef SYNC_CHAR
`define SYNC_CHAR 37'h1_0F0F_0F0F
`endif

module pcs_tx_seq_ctrl #(
  parameter int unsigned BURST_LEN       = 4,
  parameter int unsigned RESYNC_INTERVAL = 4096,
  parameter bit          RESYNC_EN       = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tx_ready,
  input  logic         align_req,
  input  logic         pay_valid,
  input  logic [191:0] pay_data,
  input  logic         pay_last,
  output logic         pay_pop,
  output logic [191:0] out_data,
  output logic         out_txen,
  output logic         align_done,
  output logic         underrun,
  output logic [2:0]   state_o
);

  localparam int unsigned PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TW = (RESYNC_INTERVAL > 1) ? $clog2(RESYNC_INTERVAL) : 1;

  localparam logic [PW-1:0] PH_LAST = PW'(BURST_LEN - 1);
  localparam logic [TW-1:0] T_HIT   = TW'(RESYNC_INTERVAL - 1);

  localparam logic [2:0] S_ESC  = 3'd0;
  localparam logic [2:0] S_IDL  = 3'd1;
  localparam logic [2:0] S_SYN  = 3'd2;
  localparam logic [2:0] S_LINK = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;

  localparam logic [191:0] W_ESC  = {4{`ESC_CHAR}};
  localparam logic [191:0] W_IDLE = {4{`IDLE_CHAR}};
  localparam logic [191:0] W_SYNC = {4{{`SYNC_CHAR, 11'h0}}};

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          align_done_q, underrun_q;

  logic          xfer;
  logic          in_link;
  logic          phase_wrap;
  logic          service;
  logic          under_now;
  logic          done_now;
  logic          timer_hit;
  logic [TW-1:0] timer_inc;

  assign xfer       = tx_ready & reset_n;
  assign in_link    = (state_q == S_LINK) || (state_q == S_DATA);
  assign phase_wrap = (phase_q == PH_LAST);
  assign timer_inc  = timer_q + TW'(1);

  assign out_txen   = xfer;
  assign align_done = align_done_q;
  assign underrun   = underrun_q;
  assign state_o    = state_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    out_data  = W_ESC;
    pay_pop   = 1'b0;
    service   = 1'b0;
    under_now = 1'b0;
    done_now  = 1'b0;
    case (state_q)
      S_ESC: begin
        out_data = W_ESC;
        if (xfer) begin
          if (phase_wrap) begin
            phase_d = '0;
            state_d = S_IDL;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      S_IDL: begin
        out_data = W_IDLE;
        if (xfer) begin
          if (phase_wrap) begin
            phase_d = '0;
            state_d = S_SYN;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      S_SYN: begin
        out_data = W_SYNC;
        if (xfer) begin
          if (phase_wrap) begin
            phase_d  = '0;
            state_d  = S_LINK;
            done_now = 1'b1;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      S_LINK: begin
        // Pending alignment is only honoured here, so frames are never cut.
        out_data = W_IDLE;
        if (xfer) begin
          if (pending_q) begin
            state_d = S_ESC;
            phase_d = '0;
            service = 1'b1;
          end else if (pay_valid) begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pay_valid) begin
          out_data = pay_data;
          pay_pop  = xfer;
          if (xfer && pay_last) begin
            state_d = S_LINK;
          end
        end else begin
          out_data  = W_IDLE;
          under_now = xfer;
        end
      end
      default: begin
        state_d = S_ESC;
        phase_d = '0;
      end
    endcase
  end

  // Timer freezes once a request is pending so multiple triggers fold into one sequence.
  always_comb begin
    timer_d   = timer_q;
    timer_hit = 1'b0;
    if (done_now) begin
      timer_d = '0;
    end else if (RESYNC_EN && xfer && in_link && !pending_q) begin
      timer_d   = timer_inc;
      timer_hit = (timer_inc == T_HIT);
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (service) begin
      pending_d = 1'b0;
    end else if ((align_req && in_link) || timer_hit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_ESC;
      phase_q      <= '0;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      align_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      align_done_q <= done_now;
      underrun_q   <= under_now;
    end
  end

endmodule

// File: tb/tb_pcs_tx_seq_ctrl.sv
// Directed bench for pcs_tx_seq_ctrl with a show-ahead FIFO model and a transfer recorder.
// Built with RESYNC_INTERVAL=16 so the periodic realignment is reachable in a short run.
module tb_pcs_tx_seq_ctrl;

  localparam logic [191:0] W_ESC  = {4{48'h1C1C_1C1C_1C1C}};
  localparam logic [191:0] W_IDLE = {4{48'h0707_0707_0707}};
  localparam logic [191:0] W_SYNC = {4{48'h0878_7878_7800}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tx_ready = 1'b0;
  logic         align_req = 1'b0;
  logic         pay_valid = 1'b0;
  logic [191:0] pay_data = '0;
  logic         pay_last = 1'b0;
  logic         pay_pop;
  logic [191:0] out_data;
  logic         out_txen;
  logic         align_done;
  logic         underrun;
  logic [2:0]   state_o;

  pcs_tx_seq_ctrl #(
    .BURST_LEN(4), .RESYNC_INTERVAL(16), .RESYNC_EN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tx_ready(tx_ready), .align_req(align_req),
    .pay_valid(pay_valid), .pay_data(pay_data), .pay_last(pay_last),
    .pay_pop(pay_pop), .out_data(out_data), .out_txen(out_txen),
    .align_done(align_done), .underrun(underrun), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [191:0] wq[$];
  logic [2:0]   sq[$];
  logic         pq[$];
  int           ad_cnt = 0;
  int           ad_at  = -1;
  int           ur_cnt = 0;

  always @(negedge clk) begin
    if (align_done) begin
      ad_cnt++;
      ad_at = wq.size();
    end
    if (underrun) ur_cnt++;
    if (out_txen) begin
      wq.push_back(out_data);
      sq.push_back(state_o);
      pq.push_back(pay_pop);
    end
  end

  int wbase, adbase, urbase;
  logic [192:0] fq[$];
  logic         stall = 1'b0;
  logic         pop_s;
  logic [192:0] tmp;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] dat(input int k);
    return {6{32'hD000_0000 | k}};
  endfunction

  function automatic logic [191:0] exp_pre(input int k);
    if (k < 4) return W_ESC;
    if (k < 8) return W_IDLE;
    if (k < 12) return W_SYNC;
    return W_IDLE;
  endfunction

  function automatic logic [191:0] wd(input int k);
    if (wbase + k < wq.size()) return wq[wbase + k];
    return 'x;
  endfunction

  function automatic logic [191:0] st(input int k);
    if (wbase + k < sq.size()) return {189'd0, sq[wbase + k]};
    return 'x;
  endfunction

  function automatic logic [191:0] pp(input int k);
    if (wbase + k < pq.size()) return {191'd0, pq[wbase + k]};
    return 'x;
  endfunction

  task automatic drive_fifo();
    if (fq.size() > 0 && !stall) begin
      pay_valid = 1'b1;
      {pay_last, pay_data} = fq[0];
    end else begin
      pay_valid = 1'b0;
      pay_last  = 1'b0;
      pay_data  = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk) pop_s = pay_pop;
    @(posedge clk);
    #1;
    if (pop_s && fq.size() > 0) tmp = fq.pop_front();
    drive_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic mark();
    wbase  = wq.size();
    adbase = ad_cnt;
    urbase = ur_cnt;
  endtask

  task automatic load(input int n);
    for (int k = 1; k <= n; k++) fq.push_back({(k == n), dat(k)});
    drive_fifo();
  endtask

  task automatic rst(input logic rdy);
    reset_n   = 1'b0;
    tx_ready  = rdy;
    align_req = 1'b0;
    stall     = 1'b0;
    fq.delete();
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    mark();
    reset_n = 1'b1;
  endtask

  task automatic chk_pre(input string tag, input int off);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("%s_w%0d", tag, k), wd(off + k), exp_pre(k));
      chk($sformatf("%s_s%0d", tag, k), st(off + k), 192'(k / 4));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    tx_ready = 1'b1;
    #12;
    chk("rst_txen", {191'd0, out_txen}, 192'd0);
    chk("rst_data", out_data, W_ESC);
    chk("rst_pop", {191'd0, pay_pop}, 192'd0);
    chk("rst_state", {189'd0, state_o}, 192'd0);
    chk("rst_ad", {191'd0, align_done}, 192'd0);
    chk("rst_ur", {191'd0, underrun}, 192'd0);

    // Preamble after reset, then idle link
    rst(1'b1);
    run(20);
    chk("s1_ntx", 192'(wq.size() - wbase), 192'd20);
    chk_pre("s1", 0);
    for (int k = 12; k < 20; k++) begin
      chk($sformatf("s1_li_w%0d", k), wd(k), W_IDLE);
      chk($sformatf("s1_li_s%0d", k), st(k), 192'd3);
    end
    chk("s1_adcnt", 192'(ad_cnt - adbase), 192'd1);
    chk("s1_adat", 192'(ad_at - wbase), 192'd12);
    chk("s1_state", {189'd0, state_o}, 192'd3);

    // Preamble with tx_ready toggling
    rst(1'b1);
    for (int i = 0; i < 24; i++) begin
      tx_ready = (i % 2 == 0);
      #1;
      if (!tx_ready) chk($sformatf("s2_hold%0d", i), out_data, exp_pre((i + 1) / 2));
      tick();
    end
    chk("s2_ntx", 192'(wq.size() - wbase), 192'd12);
    chk_pre("s2", 0);
    chk("s2_adcnt", 192'(ad_cnt - adbase), 192'd1);
    chk("s2_state", {189'd0, state_o}, 192'd3);

    // 3-word frame from LINK_IDLE
    rst(1'b1);
    run(12);
    mark();
    load(3);
    run(8);
    chk("s3_w0", wd(0), W_IDLE);
    chk("s3_p0", pp(0), 192'd0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("s3_w%0d", k), wd(k), dat(k));
      chk($sformatf("s3_p%0d", k), pp(k), 192'd1);
      chk($sformatf("s3_s%0d", k), st(k), 192'd4);
    end
    chk("s3_w4", wd(4), W_IDLE);
    chk("s3_s4", st(4), 192'd3);
    chk("s3_p4", pp(4), 192'd0);

    // align_req mid-frame, second request inside the preamble
    rst(1'b1);
    run(12);
    mark();
    load(5);
    run(2);
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    run(7);
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    run(20);
    chk("s4_w0", wd(0), W_IDLE);
    for (int k = 1; k <= 5; k++) chk($sformatf("s4_d%0d", k), wd(k), dat(k));
    chk("s4_w6", wd(6), W_IDLE);
    chk("s4_s6", st(6), 192'd3);
    chk_pre("s4", 7);
    for (int k = 19; k < 31; k++) chk($sformatf("s4_li_s%0d", k), st(k), 192'd3);
    chk("s4_adcnt", 192'(ad_cnt - adbase), 192'd2);

    // Mid-frame underrun for two cycles
    rst(1'b1);
    run(12);
    mark();
    load(4);
    run(3);
    stall = 1'b1;
    drive_fifo();
    run(2);
    stall = 1'b0;
    drive_fifo();
    run(5);
    chk("s5_w1", wd(1), dat(1));
    chk("s5_w2", wd(2), dat(2));
    for (int k = 3; k <= 4; k++) begin
      chk($sformatf("s5_u_w%0d", k), wd(k), W_IDLE);
      chk($sformatf("s5_u_s%0d", k), st(k), 192'd4);
      chk($sformatf("s5_u_p%0d", k), pp(k), 192'd0);
    end
    chk("s5_w5", wd(5), dat(3));
    chk("s5_w6", wd(6), dat(4));
    chk("s5_w7", wd(7), W_IDLE);
    chk("s5_s7", st(7), 192'd3);
    chk("s5_urcnt", 192'(ur_cnt - urbase), 192'd2);

    // Periodic realignment after 16 idle transfers
    rst(1'b1);
    run(12);
    mark();
    run(40);
    for (int k = 0; k < 16; k++) chk($sformatf("s6_w%0d", k), wd(k), W_IDLE);
    chk_pre("s6", 16);
    chk("s6_adcnt", 192'(ad_cnt - adbase), 192'd2);
    chk("s6_adat", 192'(ad_at - wbase), 192'd28);

    // Async reset mid-SYN restarts at ESC
    rst(1'b1);
    run(9);
    chk("s7_insyn", {189'd0, state_o}, 192'd2);
    reset_n = 1'b0;
    #1;
    chk("s7_rstate", {189'd0, state_o}, 192'd0);
    chk("s7_rtxen", {191'd0, out_txen}, 192'd0);
    chk("s7_rdata", out_data, W_ESC);
    rst(1'b1);
    run(13);
    chk_pre("s7", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pcs_tx_seq_ctrl.md
Name: pcs_tx_seq_ctrl

Overview:
- Transmit-side sequencer for the 25G PCS 192-bit datapath; sits between the payload FIFO and the TX encoder.
- After reset it drives the link-alignment preamble: 4 ESC words, then 4 IDLE words, then 4 SYNC words.
- It then arbitrates the datapath between IDLE fill and payload frames.
- It re-runs the preamble on request or periodically, and never interrupts a frame to do so.

Parameters:
BURST_LEN, 4, words per preamble phase (ESC, IDLE, SYNC each)
RESYNC_INTERVAL, 4096, transfers from align_done to automatic re-alignment request
RESYNC_EN, 1, 1 enables the periodic re-alignment timer

Ports:
clk  input  1  datapath clock
reset_n  input  1  asynchronous active-low reset
tx_ready  input  1  downstream accepts a word this cycle
align_req  input  1  single-cycle request for a preamble sequence
pay_valid  input  1  payload FIFO head word valid (show-ahead)
pay_data  input  192  payload FIFO head word
pay_last  input  1  head word is the last word of its frame
pay_pop  output  1  pops the FIFO head; combinational
out_data  output  192  word to encoder; combinational from state
out_txen  output  1  word valid/transferred; combinational
align_done  output  1  registered 1-cycle pulse after the last SYNC transfer
underrun  output  1  registered 1-cycle pulse when a DATA-state word is filled with IDLE
state_o  output  3  current state encoding

Behaviour:
- Constants come from the shared PCS defines:
  - ESC word = {4{`ESC_CHAR}}
  - IDLE word = {4{`IDLE_CHAR}}
  - SYNC word = {4{{`SYNC_CHAR,11'h0}}}
- Transfer: a cycle with out_txen=1. All counters advance only on transfers.
- out_txen = tx_ready in every state, so a word is always offered. out_txen = 0 while reset_n = 0.
- States and state_o encoding: ESC=0, IDL=1, SYN=2, LINK_IDLE=3, DATA=4.
- Reset values: state ESC, phase counter 0, align_pending 0, resync timer 0, align_done 0, underrun 0.
  - out_data shows the ESC word; pay_pop is 0.
  - Reset is asserted or released mid-operation: the sequence restarts at ESC with phase counter 0. No partial frame is resumed.
- ESC, IDL, SYN states:
  - out_data is the phase word.
  - The phase counter (width clog2(BURST_LEN)) wraps to 0 on the BURST_LEN-th transfer, and the state advances ESC->IDL->SYN->LINK_IDLE.
  - On SYN->LINK_IDLE, align_done pulses the following cycle and the resync timer clears.
  - align_req is ignored in these states.
- LINK_IDLE state:
  - out_data is the IDLE word; pay_pop = 0.
  - On a transfer: if align_pending, go to ESC, clear align_pending and the phase counter. Else if pay_valid, go to DATA. Else stay.
  - Without a transfer, the state holds.
- DATA state:
  - If pay_valid: out_data = pay_data and pay_pop = tx_ready.
  - A pop with pay_last goes to LINK_IDLE.
  - If !pay_valid (mid-frame underrun): out_data is the IDLE word, pay_pop = 0, underrun pulses the next cycle, and the state stays DATA.
- align_pending:
  - Set by align_req in LINK_IDLE or DATA.
  - Set by the timer when RESYNC_EN and the timer reaches RESYNC_INTERVAL-1 transfers.
  - Held until serviced from LINK_IDLE. Multiple requests collapse into one sequence.
  - align_req in the same cycle as the LINK_IDLE->ESC transition is absorbed, not re-latched.
- Resync timer:
  - Counts transfers in LINK_IDLE and DATA.
  - Saturates while align_pending = 1.
  - Width clog2(RESYNC_INTERVAL).
- Frame with pay_last on its first word: single-word frame, DATA lasts one transfer.
- tx_ready low for any duration: state, counters and out_data hold. pay_pop = 0.

Test Plan:
- Reset release, tx_ready=1, no payload:
  - Transfers 0-3 carry the ESC word, 4-7 the IDLE word, 8-11 the SYNC word.
  - align_done pulses once, one cycle after transfer 11.
  - State then stays 3 with the IDLE word.
- Preamble with tx_ready toggling 1,0,1,0: exactly 12 preamble transfers occur, and out_data is stable during ready=0 cycles.
- 3-word frame (pay_last on word 3) in LINK_IDLE:
  - One IDLE transfer, then 3 payload words with pay_pop each.
  - Return to state 3; next word is IDLE.
- align_req pulsed on the 2nd word of a 5-word frame:
  - Frame completes intact.
  - One IDLE transfer, then the 12-word preamble.
  - A second align_req inside the preamble causes no extra sequence.
- pay_valid dropped for 2 cycles mid-frame:
  - 2 IDLE words with out_txen=1 and 2 underrun pulses.
  - Frame resumes with the correct next word.
- RESYNC_INTERVAL=16, idle link: the preamble restarts after 16 IDLE transfers following align_done. Async reset mid-SYN restarts at ESC.
